// File: rtl/d_mem_responder.sv
// Word-addressed data RAM answering CPU load/store requests through a req/busy/done
// handshake after a fixed number of wait states.
module d_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LAT         = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr_en,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_state_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic        r_wr;
  logic [31:0] r_adr;
  logic [31:0] r_data;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_data_out;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_complete;
  logic [32:0] w_diff;
  logic        w_bad;
  logic [AW-1:0] w_idx;

  // Bit 32 of the widened subtraction is the borrow, i.e. address below the base.
  assign w_diff     = {1'b0, r_adr} - {1'b0, BASE_ADDR};
  assign w_bad      = (r_adr[1:0] != 2'b00) | w_diff[32]
                    | ({2'b00, w_diff[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx      = w_diff[AW+1:2];
  assign w_complete = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept  = 1'b1;
          w_state_n = S_WAIT;
          w_cnt_n   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) w_cnt_n = r_cnt - 4'd1;
        else               w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wr       <= 1'b0;
      r_adr      <= 32'd0;
      r_data     <= 32'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_complete;
      if (w_accept) begin
        r_wr   <= wr_en;
        r_adr  <= adr;
        r_data <= data_in;
      end
      if (w_complete) begin
        if (w_bad) begin
          r_err      <= 1'b1;
          r_data_out <= 32'd0;
        end else begin
          r_err <= 1'b0;
          if (!r_wr) r_data_out <= r_mem[w_idx];
        end
      end
    end
  end

  // RAM is outside the reset domain; an aborted access never reaches completion.
  always_ff @(posedge clk) begin
    if (w_complete && r_wr && !w_bad) r_mem[w_idx] <= r_data;
  end

  assign busy     = (r_state == S_WAIT);
  assign done     = r_done;
  assign err      = r_err;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_d_mem_responder.sv
// tb/tb_d_mem_responder.sv - directed vector bench for d_mem_responder (LAT=4 and LAT=1 builds)
module tb_d_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr_en = 1'b0;
  logic [31:0] adr = '0, data_in = '0;
  logic        busy, done, err;
  logic [31:0] data_out;

  logic        req1 = 1'b0, wr1 = 1'b0;
  logic [31:0] adr1 = '0, din1 = '0;
  logic        busy1, done1, err1;
  logic [31:0] dout1;

  d_mem_responder #(.DEPTH_WORDS(1024), .LAT(4), .BASE_ADDR(32'h0)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .adr(adr), .data_in(data_in),
    .busy(busy), .done(done), .err(err), .data_out(data_out));

  d_mem_responder #(.DEPTH_WORDS(16), .LAT(1), .BASE_ADDR(32'h100)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wr_en(wr1), .adr(adr1), .data_in(din1),
    .busy(busy1), .done(done1), .err(err1), .data_out(dout1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  // One access on the LAT=4 instance: latency, busy profile, err, data_out and done width.
  task automatic acc4(input string name, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_dout);
    int lat;
    @(negedge clk);
    req = 1'b1; wr_en = w; adr = a; data_in = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      chk({name, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'd4);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({name, "_err"}, 32'(err), 32'(e_err));
    chk({name, "_dout"}, data_out, e_dout);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic acc1(input string name, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_dout);
    @(negedge clk);
    req1 = 1'b1; wr1 = w; adr1 = a; din1 = d;
    @(posedge clk); #1;
    req1 = 1'b0;
    chk({name, "_busy"}, 32'(busy1), 32'd1);
    chk({name, "_done_early"}, 32'(done1), 32'd0);
    @(posedge clk); #1;
    chk({name, "_done"}, 32'(done1), 32'd1);
    chk({name, "_err"}, 32'(err1), 32'(e_err));
    chk({name, "_dout"}, dout1, e_dout);
  endtask

  vec_t vecs[12];
  int   ndone;
  logic [15:0] amask;
  logic prev_busy;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0042, 32'h1234_5678, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h0000_AAAA, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_AAAA};
    vecs[9]  = '{1'b0, 32'h0000_0041, 32'h0,         1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      acc4($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d,
           vecs[i].exp_err, vecs[i].exp_dout);

    // Reset two edges into a store to 0x10 must abort it.
    @(negedge clk);
    req = 1'b1; wr_en = 1'b1; adr = 32'h10; data_in = 32'h0000_5555;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", data_out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    acc4("abort_reload", 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_AAAA);

    // req held high: accept, LAT wait edges, done cycle, then next accept.
    amask = '0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req = 1'b1; wr_en = 1'b0; adr = 32'h40 + 32'(4 * k);
      prev_busy = busy;
      @(posedge clk); #1;
      if (busy && !prev_busy) amask[k] = 1'b1;
      if (done) ndone++;
    end
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("b2b_accepts", 32'(amask), 32'h0000_0421);
    chk("b2b_dones", 32'(ndone), 32'd3);

    acc1("l1_store_last", 1'b1, 32'h0000_013C, 32'h1111_2222, 1'b0, 32'h0);
    acc1("l1_load_last", 1'b0, 32'h0000_013C, 32'h0, 1'b0, 32'h1111_2222);
    acc1("l1_below_base", 1'b0, 32'h0000_00FC, 32'h0, 1'b1, 32'h0);
    acc1("l1_past_end", 1'b0, 32'h0000_0140, 32'h0, 1'b1, 32'h0);
    acc1("l1_reload", 1'b0, 32'h0000_013C, 32'h0, 1'b0, 32'h1111_2222);

    amask = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req1 = 1'b1; wr1 = 1'b0; adr1 = 32'h13C;
      @(posedge clk); #1;
      if (done1) amask[k] = 1'b1;
    end
    @(negedge clk);
    req1 = 1'b0;
    chk("l1_done_pattern", 32'(amask), 32'h0000_00AA);
    chk("l1_stream_dout", dout1, 32'h1111_2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
